// File: rtl/ship_sprite_arbiter.sv
// ship_sprite_arbiter: round-robin sharing of the combinational ship-sprite ROM.
//
// Requesters (player ship, reserve-life icons, captured ship, ...) raise req with
// sprite-local X/Y coordinates. One request is granted per cycle, combinationally.
// The granted lookup then runs through a 2-stage registered pipeline:
//   stage 1: registers coordinates onto rom_x/rom_y, plus the valid, id and oob flags
//   stage 2: captures the ROM colour and presents it on rd_* with the requester id
// Out-of-range coordinates never reach the ROM. They return black, transparent, with rd_oob set.
//
// Optional feature, selected by the macro SHIP_ARB_PRIO0_EN:
//   defined   - requester 0 has absolute priority. The pointer cycles over 1..NUM_REQ-1 only.
//   undefined - plain round-robin over all NUM_REQ requesters.

module ship_sprite_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned SPRITE_W = 17,
  parameter int unsigned SPRITE_H = 19
) (
  input  logic                  Clk,
  input  logic                  Reset,

  // Requester side
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_x,
  input  logic [NUM_REQ*10-1:0] req_y,
  output logic [NUM_REQ-1:0]    gnt,

  // Sprite ROM side
  output logic [9:0]            rom_x,
  output logic [9:0]            rom_y,
  input  logic [7:0]            rom_r,
  input  logic [7:0]            rom_g,
  input  logic [7:0]            rom_b,

  // Result side
  output logic                  rd_valid,
  output logic [ID_W-1:0]       rd_id,
  output logic [7:0]            rd_r,
  output logic [7:0]            rd_g,
  output logic [7:0]            rd_b,
  output logic                  rd_transparent,
  output logic                  rd_oob
);

  // ---------------------------------------------------------------------------
  // Arbitration state and combinational grant selection
  // ---------------------------------------------------------------------------

  logic [ID_W-1:0]    ptr;          // round-robin search start
  logic [ID_W-1:0]    ptrNext;
  logic               ptrAdvance;

  logic [NUM_REQ-1:0] eligible;     // requests taking part in round-robin
  logic [NUM_REQ-1:0] upperMask;    // indices at or above ptr

  logic               hiAny;
  logic [ID_W-1:0]    hiIdx;
  logic               loAny;
  logic [ID_W-1:0]    loIdx;

  logic               prio0;        // requester 0 wins outright (feature build only)
  logic               anyGnt;
  logic [ID_W-1:0]    gntIdx;

  logic [9:0]         selX;
  logic [9:0]         selY;
  logic               selOob;

  // Build the round-robin candidate set and the "at or above ptr" mask
  always_comb begin
    eligible = req;
`ifdef SHIP_ARB_PRIO0_EN
    // Requester 0 is handled by the fixed-priority path, never by round-robin
    eligible[0] = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      upperMask[i] = (ID_W'(i) >= ptr);
    end
  end

  // Find the lowest eligible index at/above ptr, and the lowest overall for wrap-around
  always_comb begin
    hiAny = 1'b0;
    hiIdx = '0;
    loAny = 1'b0;
    loIdx = '0;
    // Scan downwards so the last hit is the lowest index
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (eligible[i] && upperMask[i]) begin
        hiAny = 1'b1;
        hiIdx = ID_W'(i);
      end
      if (eligible[i]) begin
        loAny = 1'b1;
        loIdx = ID_W'(i);
      end
    end
  end

  // Resolve the final grant. Reset forces the grant low.
  always_comb begin
    prio0 = 1'b0;
`ifdef SHIP_ARB_PRIO0_EN
    prio0 = req[0];
`endif
    anyGnt     = (prio0 | hiAny | loAny) & ~Reset;
    gntIdx     = prio0 ? '0 : (hiAny ? hiIdx : loIdx);
    // A fixed-priority win by requester 0 leaves the round-robin order untouched
    ptrAdvance = anyGnt & ~prio0;

    gnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      gnt[i] = anyGnt && (gntIdx == ID_W'(i));
    end
  end

  // Next pointer: one past the granted index, wrapping within the rotating range
  always_comb begin
    if (gntIdx == ID_W'(NUM_REQ - 1)) begin
`ifdef SHIP_ARB_PRIO0_EN
      ptrNext = ID_W'(1);
`else
      ptrNext = '0;
`endif
    end else begin
      ptrNext = gntIdx + ID_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= '0;
    end else if (ptrAdvance) begin
      ptr <= ptrNext;
    end
  end

  // Mux out the granted requester's coordinates and range-check them
  always_comb begin
    selX = '0;
    selY = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gntIdx == ID_W'(i)) begin
        selX = req_x[i*10 +: 10];
        selY = req_y[i*10 +: 10];
      end
    end
    // Unsigned compare with no wrap: 17..1023 / 19..1023 are all out of range
    selOob = (selX >= 10'(SPRITE_W)) || (selY >= 10'(SPRITE_H));
  end

  // ---------------------------------------------------------------------------
  // Stage 1: ROM address register plus tag/flag sideband
  // ---------------------------------------------------------------------------

  logic            s1Valid;
  logic [ID_W-1:0] s1Id;
  logic            s1Oob;

  // Capture the accepted lookup. The address holds when nothing is granted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1Valid <= 1'b0;
      s1Id    <= '0;
      s1Oob   <= 1'b0;
      rom_x   <= '0;
      rom_y   <= '0;
    end else begin
      s1Valid <= anyGnt;
      if (anyGnt) begin
        s1Id  <= gntIdx;
        s1Oob <= selOob;
        // Park the ROM at 0/0 for out-of-range requests so it is never over-indexed
        rom_x <= selOob ? 10'd0 : selX;
        rom_y <= selOob ? 10'd0 : selY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: capture ROM colour and present the tagged result
  // ---------------------------------------------------------------------------

  logic romBlack;

  // The colour 0x000000 is the sprite's transparent key
  always_comb begin
    romBlack = ~|(rom_r | rom_g | rom_b);
  end

  // Result register. Payload holds when stage 1 carries no lookup.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid       <= 1'b0;
      rd_id          <= '0;
      rd_r           <= '0;
      rd_g           <= '0;
      rd_b           <= '0;
      rd_transparent <= 1'b0;
      rd_oob         <= 1'b0;
    end else begin
      rd_valid <= s1Valid;
      if (s1Valid) begin
        rd_id          <= s1Id;
        rd_oob         <= s1Oob;
        rd_r           <= s1Oob ? 8'h00 : rom_r;
        rd_g           <= s1Oob ? 8'h00 : rom_g;
        rd_b           <= s1Oob ? 8'h00 : rom_b;
        rd_transparent <= s1Oob | romBlack;
      end
    end
  end

endmodule

// File: tb/tb_ship_sprite_arbiter.sv
// Directed bench for ship_sprite_arbiter with a small behavioural sprite ROM.
// Honours SHIP_ARB_PRIO0_EN: the fixed-priority scenario replaces the pure
// round-robin and mid-flight-reset scenarios when that macro is defined.

module tb_ship_sprite_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  req;
  logic [39:0] req_x;
  logic [39:0] req_y;
  logic [3:0]  gnt;
  logic [9:0]  rom_x;
  logic [9:0]  rom_y;
  logic [7:0]  rom_r;
  logic [7:0]  rom_g;
  logic [7:0]  rom_b;
  logic        rd_valid;
  logic [1:0]  rd_id;
  logic [7:0]  rd_r;
  logic [7:0]  rd_g;
  logic [7:0]  rd_b;
  logic        rd_transparent;
  logic        rd_oob;

  int nVec = 0;
  int nErr = 0;

  ship_sprite_arbiter #(
    .NUM_REQ  (4),
    .ID_W     (2),
    .SPRITE_W (17),
    .SPRITE_H (19)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .req            (req),
    .req_x          (req_x),
    .req_y          (req_y),
    .gnt            (gnt),
    .rom_x          (rom_x),
    .rom_y          (rom_y),
    .rom_r          (rom_r),
    .rom_g          (rom_g),
    .rom_b          (rom_b),
    .rd_valid       (rd_valid),
    .rd_id          (rd_id),
    .rd_r           (rd_r),
    .rd_g           (rd_g),
    .rd_b           (rd_b),
    .rd_transparent (rd_transparent),
    .rd_oob         (rd_oob)
  );

  always #5 Clk = ~Clk;

  // Behavioural sprite ROM: a few fixed pixels, a simple pattern elsewhere
  function automatic logic [23:0] romModel(input logic [9:0] x, input logic [9:0] y);
    if (x == 10'd8 && y == 10'd1) return 24'hDEDEDE;
    if (x == 10'd8 && y == 10'd9) return 24'hFF0000;
    if (x == 10'd0 && y == 10'd0) return 24'h000000;
    return {x[7:0] + 8'h10, y[7:0] + 8'h20, 8'h5A};
  endfunction

  assign {rom_r, rom_g, rom_b} = romModel(rom_x, rom_y);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setCoord(input int i, input logic [9:0] x, input logic [9:0] y);
    req_x[i*10 +: 10] = x;
    req_y[i*10 +: 10] = y;
  endtask

  task automatic resetDut();
    Reset = 1'b1;
    req   = '0;
    tick();
    Reset = 1'b0;
  endtask

  // Single isolated lookup followed through both pipeline stages
  task automatic lookup(input string tag, input int i, input logic [9:0] x,
                        input logic [9:0] y, input logic [23:0] expRgb,
                        input logic expTr, input logic expOob);
    req = 4'(1 << i);
    setCoord(i, x, y);
    #1;
    chk({tag, "/gnt"}, 32'(gnt), 32'(1 << i));
    tick();
    req = '0;
    chk({tag, "/rom_x"}, 32'(rom_x), expOob ? 32'd0 : 32'(x));
    chk({tag, "/rom_y"}, 32'(rom_y), expOob ? 32'd0 : 32'(y));
    chk({tag, "/valid_early"}, 32'(rd_valid), 32'd0);
    tick();
    chk({tag, "/valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "/id"}, 32'(rd_id), 32'(i));
    chk({tag, "/rgb"}, 32'({rd_r, rd_g, rd_b}), 32'(expRgb));
    chk({tag, "/transp"}, 32'(rd_transparent), 32'(expTr));
    chk({tag, "/oob"}, 32'(rd_oob), 32'(expOob));
  endtask

  initial begin
    Reset = 1'b1;
    req   = 4'b1111;
    req_x = '0;
    req_y = '0;
    tick();
    tick();

    // Reset state, with every req raised to show the grant is held low
    chk("rst/gnt", 32'(gnt), 32'd0);
    chk("rst/rom_xy", 32'({rom_x, rom_y}), 32'd0);
    chk("rst/valid", 32'(rd_valid), 32'd0);
    chk("rst/id", 32'(rd_id), 32'd0);
    chk("rst/rgb", 32'({rd_r, rd_g, rd_b}), 32'd0);
    chk("rst/flags", 32'({rd_transparent, rd_oob}), 32'd0);

    // First cycle out of reset: normal arbitration from index 0
    Reset = 1'b0;
    req   = '0;
    lookup("t1", 0, 10'd8, 10'd1, 24'hDEDEDE, 1'b0, 1'b0);

    lookup("t2a", 2, 10'd8, 10'd9, 24'hFF0000, 1'b0, 1'b0);
    lookup("t2b", 2, 10'd0, 10'd0, 24'h000000, 1'b1, 1'b0);

    // Non-zero address first, so the forced 0/0 below is visible
    lookup("pre", 3, 10'd5, 10'd6, 24'h15265A, 1'b0, 1'b0);
    lookup("t4a", 1, 10'd20, 10'd5, 24'h000000, 1'b1, 1'b1);
    lookup("t4b", 1, 10'd3, 10'd19, 24'h000000, 1'b1, 1'b1);

`ifndef SHIP_ARB_PRIO0_EN
    // All four requesters held for 8 cycles, starting from ptr=0
    resetDut();
    for (int i = 0; i < 4; i++) setCoord(i, 10'(i + 1), 10'(i + 2));
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk($sformatf("t3/gnt%0d", k), 32'(gnt), (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
      if (k >= 2) begin
        chk($sformatf("t3/valid%0d", k), 32'(rd_valid), 32'd1);
        chk($sformatf("t3/id%0d", k), 32'(rd_id), 32'((k - 2) % 4));
        chk($sformatf("t3/r%0d", k), 32'(rd_r), 32'(8'h11 + 8'((k - 2) % 4)));
      end
      tick();
    end
    chk("t3/drain", 32'(rd_valid), 32'd0);

    // Reset with two lookups in flight (grants 0 then 1, ptr left at 2)
    req = 4'b1111;
    #1;
    chk("t5/gntA", 32'(gnt), 32'b0001);
    tick();
    #1;
    chk("t5/gntB", 32'(gnt), 32'b0010);
    tick();
    Reset = 1'b1;
    #1;
    chk("t5/gnt_in_rst", 32'(gnt), 32'd0);
    chk("t5/validA", 32'(rd_valid), 32'd1);
    tick();
    Reset = 1'b0;
    #1;
    chk("t5/gnt_after", 32'(gnt), 32'b0001);
    chk("t5/valid_after", 32'(rd_valid), 32'd0);
    tick();
    req = '0;
    chk("t5/no_stale", 32'(rd_valid), 32'd0);
    tick();
    chk("t5/new_valid", 32'(rd_valid), 32'd1);
    chk("t5/new_id", 32'(rd_id), 32'd0);
    tick();
    chk("t5/drain", 32'(rd_valid), 32'd0);
`else
    // Requester 0 pre-empts round-robin, which rotates over 1..3 only
    resetDut();
    for (int i = 0; i < 4; i++) setCoord(i, 10'(i + 1), 10'(i + 2));
    req = 4'b1110;
    #1;
    chk("t6/gnt0", 32'(gnt), 32'b0010);
    tick();
    #1;
    chk("t6/gnt1", 32'(gnt), 32'b0100);
    tick();
    req = 4'b1111;
    for (int k = 2; k < 5; k++) begin
      #1;
      chk($sformatf("t6/gnt%0d", k), 32'(gnt), 32'b0001);
      if (k == 4) chk("t6/id_prio", 32'(rd_id), 32'd0);
      tick();
    end
    req = 4'b1110;
    #1;
    chk("t6/gnt5", 32'(gnt), 32'b1000);
    tick();
    req = '0;
    tick();
    chk("t6/id_last", 32'(rd_id), 32'd3);
    tick();
    chk("t6/drain", 32'(rd_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
